// File: rtl/data_mem_resp_pkg.sv
// Shared encodings for the memory-stage data responder: access sizes, direction, FSM states.
package data_mem_resp_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef enum logic [1:0] {
    SIZE_1  = 2'b00,
    SIZE_4  = 2'b01,
    SIZE_8  = 2'b10,
    SIZE_16 = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  function automatic logic [4:0] burst_beats(input logic [1:0] size);
    case (size)
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_word_ram.sv
// Single-port synchronous word array: write enable, registered read port.
// Contents have no reset; only the read-data register is cleared.
module data_mem_resp_word_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory-stage data responder: serves 1/4/8/16-word bursts from a local word array,
// stalling upstream while a multi-beat burst is in flight.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_req_in,
  input  logic [31:0] mem_address_in,
  input  logic [31:0] mem_data_in,
  input  logic [1:0]  mem_access_size_in,
  input  logic        mem_rw_in,
  output logic [31:0] mem_data_out,
  output logic        mem_valid_out,
  output logic        mem_err_out,
  output logic        stall_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_next;
  logic [AW-1:0] idx;
  logic [3:0]    cnt;
  logic          valid_r, err_r;

  logic [31:0]   offset, end_idx;
  logic [4:0]    nbeats;
  logic [AW-1:0] req_idx;
  logic          req_ok, accept, reject;

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // Addresses below the base wrap to huge offsets, so one unsigned compare
  // covers both ends of the array. BASE_ADDR is word aligned, so offset[1:0]
  // is the request's own alignment.
  assign offset  = mem_address_in - BASE_ADDR;
  assign nbeats  = burst_beats(mem_access_size_in);
  assign end_idx = {2'b00, offset[31:2]} + {27'd0, nbeats};
  assign req_ok  = (offset[1:0] == 2'b00) && (end_idx <= 32'(DEPTH_WORDS));
  assign req_idx = offset[AW+1:2];
  assign accept  = (state == IDLE) && mem_req_in && req_ok;
  assign reject  = (state == IDLE) && mem_req_in && !req_ok;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = idx;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ram_en   = 1'b1;
          ram_we   = (mem_rw_in == MEM_WR);
          ram_addr = req_idx;
          if (nbeats != 5'd1) begin
            stall_out  = 1'b1;
            state_next = (mem_rw_in == MEM_WR) ? WR : RD;
          end
        end
      end
      RD, WR: begin
        ram_en    = 1'b1;
        ram_we    = (state == WR);
        stall_out = 1'b1;
        if (cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // idx always points at the next beat to issue; cnt counts beats not yet issued.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx     <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= (accept && (mem_rw_in == MEM_RD)) || (state == RD);
      err_r   <= reject;
      if (accept) begin
        idx <= req_idx + AW'(1);
        cnt <= 4'(nbeats - 5'd1);
      end else if (state != IDLE) begin
        idx <= idx + AW'(1);
        cnt <= cnt - 4'd1;
      end
    end
  end

  data_mem_resp_word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_word_ram (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (mem_data_in),
    .rdata (ram_rdata)
  );

  assign mem_data_out  = ram_rdata;
  assign mem_valid_out = valid_r;
  assign mem_err_out   = err_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: randomized bursts checked against a word-array model.
module tb_data_mem_resp;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 1024;
  localparam int          WIN   = 20;

  logic        clk, rst_n, req, rw, valid, err, stall;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;

  data_mem_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .mem_req_in         (req),
    .mem_address_in     (addr),
    .mem_data_in        (wdata),
    .mem_access_size_in (size),
    .mem_rw_in          (rw),
    .mem_data_out       (rdata),
    .mem_valid_out      (valid),
    .mem_err_out        (err),
    .stall_out          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [16];
  logic [31:0] got_q [$];
  int          vcyc_q [$];
  int          stall_n, err_n, err_cyc;
  logic [34:0] snap;

  function automatic int beats(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (4 << (sz - 1));
  endfunction

  function automatic bit req_ok(input logic [31:0] a, input logic [1:0] sz);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 == 0) && (off >= 0) && (off / 4 + beats(sz) <= DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Commit the first lim beats of a write into the model if it would be accepted.
  task automatic model_apply(input logic [31:0] a, input logic [1:0] sz, input logic w, input int lim);
    if (req_ok(a, sz) && w) begin
      for (int k = 0; k < beats(sz) && k < lim; k++) model[word_of(a) + k] = wbuf[k];
    end
  endtask

  // Cycle 0 presents the request; an optional second request at inj_cyc and a reset at rst_cyc.
  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic w,
                        input int inj_cyc, input logic [31:0] inj_a, input logic [1:0] inj_sz,
                        input logic inj_w, input int rst_cyc);
    got_q.delete(); vcyc_q.delete();
    stall_n = 0; err_n = 0; err_cyc = -1;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      req = 1'b0; addr = $urandom; size = 2'($urandom); rw = 1'($urandom);
      wdata = (c < 16) ? wbuf[c] : $urandom;
      if (c == 0) begin
        req = 1'b1; addr = a; size = sz; rw = w;
      end else if (c == inj_cyc) begin
        req = 1'b1; addr = inj_a; size = inj_sz; rw = inj_w;
      end
      if (c == rst_cyc) rst_n = 1'b0;
      #1;
      if (c == rst_cyc) snap = {rdata, valid, err, stall};
      if (stall) stall_n++;
      if (err) begin
        err_n++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (valid) begin
        got_q.push_back(rdata);
        vcyc_q.push_back(c);
      end
    end
    req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_assert++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", rdata); end
    n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH / 16; i++) begin
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      do_req(BASE + 32'(64 * i), 2'b11, 1'b1, -1, 0, 0, 0, -1);
      n_assert++; if (err_n !== 0) begin n_fail++; $display("FAIL fill_err[%0d] got=%0d exp=0", i, err_n); end
      n_assert++; if (stall_n !== 16) begin n_fail++; $display("FAIL fill_stall[%0d] got=%0d exp=16", i, stall_n); end
      model_apply(BASE + 32'(64 * i), 2'b11, 1'b1, 16);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEAD_BEEF;
    do_req(BASE + 32'h10, 2'b00, 1'b1, -1, 0, 0, 0, -1);
    n_assert++; if (stall_n !== 0) begin n_fail++; $display("FAIL single_wr_stall got=%0d exp=0", stall_n); end
    model_apply(BASE + 32'h10, 2'b00, 1'b1, 1);
    do_req(BASE + 32'h10, 2'b00, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_rd_beats got=%0d exp=1", got_q.size()); end
    if (got_q.size() == 1) begin
      n_assert++; if (got_q[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rd_data got=%h exp=deadbeef", got_q[0]); end
      n_assert++; if (vcyc_q[0] !== 1) begin n_fail++; $display("FAIL single_rd_latency got=%0d exp=1", vcyc_q[0]); end
    end
  endtask

  task automatic test_burst4();
    for (int k = 0; k < 16; k++) wbuf[k] = 32'(k + 1);
    do_req(BASE, 2'b01, 1'b1, -1, 0, 0, 0, -1);
    n_assert++; if (stall_n !== 4) begin n_fail++; $display("FAIL burst4_wr_stall got=%0d exp=4", stall_n); end
    model_apply(BASE, 2'b01, 1'b1, 16);
    do_req(BASE, 2'b01, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL burst4_rd_beats got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_assert++; if (got_q[k] !== 32'(k + 1)) begin n_fail++; $display("FAIL burst4_rd_data[%0d] got=%h exp=%h", k, got_q[k], k + 1); end
      n_assert++; if (vcyc_q[k] !== k + 1) begin n_fail++; $display("FAIL burst4_rd_cycle[%0d] got=%0d exp=%0d", k, vcyc_q[k], k + 1); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] far;
    far = BASE + 32'(4 * (DEPTH - 8));
    do_req(BASE + 32'h2, 2'b00, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (err_n !== 1) begin n_fail++; $display("FAIL misalign_err_count got=%0d exp=1", err_n); end
    n_assert++; if (err_cyc !== 1) begin n_fail++; $display("FAIL misalign_err_cycle got=%0d exp=1", err_cyc); end
    n_assert++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL misalign_valid got=%0d exp=0", got_q.size()); end
    do_req(far, 2'b11, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (err_n !== 1) begin n_fail++; $display("FAIL oor_rd_err got=%0d exp=1", err_n); end
    n_assert++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL oor_rd_valid got=%0d exp=0", got_q.size()); end
    n_assert++; if (stall_n !== 0) begin n_fail++; $display("FAIL oor_rd_stall got=%0d exp=0", stall_n); end
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
    do_req(far, 2'b11, 1'b1, -1, 0, 0, 0, -1);
    n_assert++; if (err_n !== 1) begin n_fail++; $display("FAIL oor_wr_err got=%0d exp=1", err_n); end
    do_req(BASE - 32'd4, 2'b00, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (err_n !== 1) begin n_fail++; $display("FAIL below_base_err got=%0d exp=1", err_n); end
    do_req(far, 2'b10, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL oor_untouched_beats got=%0d exp=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 8; k++) begin
      n_assert++; if (got_q[k] !== model[DEPTH - 8 + k]) begin n_fail++; $display("FAIL oor_untouched[%0d] got=%h exp=%h", k, got_q[k], model[DEPTH - 8 + k]); end
    end
  endtask

  task automatic test_back_to_back();
    int ia, ib;
    ia = $urandom_range(0, DEPTH - 8);
    ib = $urandom_range(0, DEPTH - 1);
    do_req(BASE + 32'(4 * ia), 2'b10, 1'b0, 8, BASE + 32'(4 * ib), 2'b00, 1'b0, -1);
    n_assert++; if (got_q.size() !== 9) begin n_fail++; $display("FAIL b2b_beats got=%0d exp=9", got_q.size()); end
    n_assert++; if (stall_n !== 8) begin n_fail++; $display("FAIL b2b_stall got=%0d exp=8", stall_n); end
    for (int k = 0; k < got_q.size() && k < 9; k++) begin
      n_assert++; if (got_q[k] !== ((k < 8) ? model[ia + k] : model[ib])) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, got_q[k], (k < 8) ? model[ia + k] : model[ib]); end
      n_assert++; if (vcyc_q[k] !== k + 1) begin n_fail++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", k, vcyc_q[k], k + 1); end
    end
  endtask

  task automatic test_busy_req();
    int ia, ic;
    ia = $urandom_range(0, DEPTH - 8);
    ic = $urandom_range(0, DEPTH - 1);
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
    do_req(BASE + 32'(4 * ia), 2'b10, 1'b0, 3, BASE + 32'(4 * ic), 2'b00, 1'b1, -1);
    n_assert++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL busy_beats got=%0d exp=8", got_q.size()); end
    n_assert++; if (stall_n !== 8) begin n_fail++; $display("FAIL busy_stall got=%0d exp=8", stall_n); end
    n_assert++; if (err_n !== 0) begin n_fail++; $display("FAIL busy_err got=%0d exp=0", err_n); end
    for (int k = 0; k < got_q.size() && k < 8; k++) begin
      n_assert++; if (got_q[k] !== model[ia + k]) begin n_fail++; $display("FAIL busy_data[%0d] got=%h exp=%h", k, got_q[k], model[ia + k]); end
    end
    do_req(BASE + 32'(4 * ic), 2'b00, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (got_q.size() !== 1 || got_q[0] !== model[ic]) begin n_fail++; $display("FAIL busy_no_write got=%0d beats exp word=%h", got_q.size(), model[ic]); end
  endtask

  task automatic test_midburst_reset();
    int ia;
    ia = $urandom_range(0, DEPTH - 16);
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
    do_req(BASE + 32'(4 * ia), 2'b11, 1'b1, -1, 0, 0, 0, 5);
    n_assert++; if (snap !== 35'd0) begin n_fail++; $display("FAIL rst_outputs got=%h exp=0", snap); end
    model_apply(BASE + 32'(4 * ia), 2'b11, 1'b1, 5);
    do_req(BASE + 32'(4 * ia), 2'b11, 1'b0, -1, 0, 0, 0, -1);
    n_assert++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL rst_readback_beats got=%0d exp=16", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      n_assert++; if (got_q[k] !== model[ia + k]) begin n_fail++; $display("FAIL rst_readback[%0d] got=%h exp=%h", k, got_q[k], model[ia + k]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        w;
      int          n;
      bit          ok;
      sz = 2'($urandom);
      w  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      do_req(a, sz, w, -1, 0, 0, 0, -1);
      n  = beats(sz);
      ok = req_ok(a, sz);
      n_assert++; if (err_n !== (ok ? 0 : 1)) begin n_fail++; $display("FAIL rand_err[%0d] got=%0d exp=%0d", t, err_n, ok ? 0 : 1); end
      if (!ok) begin
        n_assert++; if (err_cyc !== 1) begin n_fail++; $display("FAIL rand_err_cycle[%0d] got=%0d exp=1", t, err_cyc); end
      end
      n_assert++; if (stall_n !== ((ok && n > 1) ? n : 0)) begin n_fail++; $display("FAIL rand_stall[%0d] got=%0d exp=%0d", t, stall_n, (ok && n > 1) ? n : 0); end
      n_assert++; if (got_q.size() !== ((ok && !w) ? n : 0)) begin n_fail++; $display("FAIL rand_beats[%0d] got=%0d exp=%0d", t, got_q.size(), (ok && !w) ? n : 0); end
      if (ok && !w) begin
        for (int k = 0; k < got_q.size() && k < n; k++) begin
          n_assert++; if (got_q[k] !== model[word_of(a) + k] || vcyc_q[k] !== k + 1) begin n_fail++; $display("FAIL rand_beat[%0d.%0d] got=%h@%0d exp=%h@%0d", t, k, got_q[k], vcyc_q[k], model[word_of(a) + k], k + 1); end
        end
      end
      model_apply(a, sz, w, 16);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; wdata = '0; size = '0; rw = 1'b0;
    for (int k = 0; k < 16; k++) wbuf[k] = '0;
    test_reset();
    test_fill();
    test_single();
    test_burst4();
    test_errors();
    test_back_to_back();
    test_busy_req();
    test_midburst_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the memory stage of the 5-stage MIPS pipeline. It accepts the registered memory request from the execute stage: address, store data, access size and read/write. It serves the request as 1, 4, 8 or 16 consecutive word beats from an internal word array. While a multi-beat request is in progress it raises `stall_out` to hold the upstream stages.

## Interface
- `BASE_ADDR`, default 32'h8002_0000: byte address of word 0 of the array.
- `DEPTH_WORDS`, default 1024: array depth in 32-bit words; must be a power of two.
- `clk_in`  input  1  CPU clock; all state changes on its rising edge.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `mem_req_in`  input  1  request strobe; qualifies the four fields below for one cycle.
- `mem_address_in`  input  32  byte address of the first beat.
- `mem_data_in`  input  32  store data; beat 0 at acceptance, beat n on the n-th cycle after.
- `mem_access_size_in`  input  2  burst length: 00 = 1, 01 = 4, 10 = 8, 11 = 16 words.
- `mem_rw_in`  input  1  0 = read, 1 = write.
- `mem_data_out`  output  32  read data for the current beat.
- `mem_valid_out`  output  1  `mem_data_out` holds a valid read beat this cycle.
- `mem_err_out`  output  1  one-cycle pulse: the request was rejected.
- `stall_out`  output  1  responder busy; upstream must hold its request.

## Operation
- States:
  - IDLE: no request in progress.
  - RD: read burst in progress.
  - WR: write burst in progress.
- IDLE with `mem_req_in`=1 accepts the request:
  - Latch the word index `(addr - BASE_ADDR) >> 2`.
  - Latch beat count N (1/4/8/16) and the direction.
  - Set the remaining-beat counter to N-1.
- Reject and stay in IDLE when `addr[1:0]` is not 00, or when any beat index falls outside [0, DEPTH_WORDS-1].
  - Behaviour on reject: pulse `mem_err_out`; no array access; no valid beats.
- Write, N=1: store `mem_data_in` at acceptance; remain IDLE.
- Write, N>1: store beat 0 at acceptance, go to WR. Each WR cycle stores `mem_data_in` at index+k and decrements the counter; the counter reaching 0 returns to IDLE.
- Read: each beat reads index+k, registered. Go to RD when N>1; the final beat returns to IDLE.
- Addressing is linear increment; there is no wrap inside a burst, because the bounds check rejects any burst that would leave the array.
- `stall_out` is combinational: 1 in RD/WR, 1 in IDLE on the acceptance cycle of an accepted N>1 request, else 0.
- `mem_req_in` while in RD/WR is a protocol violation; it is ignored with no state change.
- The array is never cleared by reset; contents persist across reset.

## Timing
- Reset values:
  - state IDLE;
  - `mem_data_out`=0, `mem_valid_out`=0, `mem_err_out`=0;
  - counter 0;
  - `stall_out`=0.
- Read latency: beat 0 appears one cycle after acceptance; beats are then back-to-back, one per cycle. N beats occupy cycles T+1 .. T+N.
- `mem_valid_out` is high exactly N cycles per accepted read.
- Write beat k data is sampled on the k-th rising edge after acceptance, with beat 0 sampled on the acceptance edge.
- Write occupancy: `stall_out` is high for N-1 cycles after acceptance plus the acceptance cycle itself; for N=1 it is never high.
- Read occupancy: `stall_out` stays high through the cycle presenting beat N-2 and drops in the cycle presenting beat N-1. This lets the next request be accepted on the final-beat cycle.
- Error: `mem_err_out` is high in cycle T+1 for a request rejected at T.
- Read-after-write to the same word in the next cycle returns the new data (write before read within the array).
- Asserting `rst_n_in` mid-burst:
  - immediate return to IDLE; outputs go to their reset values asynchronously;
  - already-written beats stay written; remaining beats are dropped.

## Structure
- Shared package/include (`const.v`):
  - access-size encodings;
  - MEM_RD/MEM_WR;
  - state encodings IDLE/RD/WR;
  - BASE_ADDR default.
- One natural sub-module, `word_ram`: single-port synchronous word array with a write enable and registered read. The FSM, counter and bounds check live in `data_mem_resp`.

## Test plan
- Single-word write then read: write 0xDEADBEEF at 0x80020010, N=1 -> `stall_out` never high. Read of the same address 2 cycles later -> one `mem_valid_out` beat of 0xDEADBEEF at T+1.
- 4-word write burst: data 1,2,3,4 at 0x80020000 -> `stall_out` high for 4 cycles. A subsequent 4-word read -> valid beats 1,2,3,4 on consecutive cycles.
- Misaligned or out-of-range request:
  - Misaligned: read at 0x80020002 -> `mem_err_out` pulse at T+1, no valid beat.
  - Out-of-range: 16-word read at BASE+4*(DEPTH_WORDS-8) -> rejected, array untouched.
- Back-to-back requests: issue a new 1-word read on the last-beat cycle of an 8-word read -> accepted; its beat immediately follows beat 7.
- Mid-burst reset:
  - Drop `rst_n_in` during beat 5 of a 16-word write -> outputs zero immediately; state IDLE.
  - Readback -> beats 0-4 written, beats 5-15 hold prior contents.
- Request while busy: pulse `mem_req_in` during an RD burst -> ignored; the burst completes unchanged.
